// File: rtl/clk_phase_checker_hyper.sv
// Quadrature clock phase checker: samples four divided clocks on both edges of clk_i
// and tracks lock/fault state with a saturating bad-cycle counter.
module clk_phase_checker_hyper #(
    parameter int unsigned LOCK_CYCLES = 8,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 clk0_i,
    input  logic                 clk90_i,
    input  logic                 clk180_i,
    input  logic                 clk270_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10,
        FAULT   = 2'b11
    } state_e;

    localparam logic [7:0]           LOCK_N  = 8'(LOCK_CYCLES);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [7:0]           good_q, good_d;
    logic                 first_q, first_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 locked_q;
    logic                 p0_q;
    logic [3:0]           n_q;
    logic [3:0]           p;
    logic                 p_ok, n_ok, tog_ok, good;

    // Bit order {clk0, clk90, clk180, clk270} for both edge samples.
    assign p = {clk0_i, clk90_i, clk180_i, clk270_i};

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) n_q <= 4'b0000;
        else         n_q <= p;
    end

    assign p_ok    = (p[3] == p[2]) && (p[1] == p[0]) && (p[3] != p[1]);
    assign n_ok    = (n_q[3] == n_q[0]) && (n_q[2] == n_q[1]) && (n_q[3] != n_q[2]);
    // The previous P0 is not meaningful on the first acquisition cycle.
    assign tog_ok  = first_q || (p[3] != p0_q);
    assign good    = p_ok && n_ok && tog_ok;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        first_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (!en_i) begin
            state_d = IDLE;
            good_d  = 8'd0;
            if (clr_i) begin
                err_d = 1'b0;
                cnt_d = '0;
            end
        end else if (clr_i) begin
            err_d  = 1'b0;
            cnt_d  = '0;
            good_d = 8'd0;
            if (state_q == LOCKED || state_q == FAULT) begin
                state_d = ACQUIRE;
                first_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    good_d  = 8'd0;
                    first_d = 1'b1;
                end
                ACQUIRE: begin
                    if (good) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 == LOCK_N) state_d = LOCKED;
                    end else begin
                        good_d = 8'd0;
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                        cnt_d   = cnt_inc;
                    end
                end
                FAULT: begin
                    if (!good) cnt_d = cnt_inc;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            good_q   <= 8'd0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            p0_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            first_q  <= first_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            locked_q <= (state_d == LOCKED);
            p0_q     <= clk0_i;
        end
    end

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_clk_phase_checker_hyper.sv
// Directed bench for clk_phase_checker_hyper: reference divide-by-2 quadrature source,
// fault injection by gating individual clocks, expectations queued and popped per step.
module tb_clk_phase_checker_hyper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, clr, en2;
    logic gen0 = 1'b0, gen90 = 1'b0;
    logic kill90 = 1'b0, kill2 = 1'b0, hold0 = 1'b0, hold_val = 1'b0;

    // clk0 toggles on posedge, clk90 follows half a clk period later.
    always @(posedge clk) gen0 <= ~gen0;
    always @(negedge clk) gen90 <= gen0;

    logic c0, c90, c180, c270, c90_2;
    assign c0    = hold0 ? hold_val : gen0;
    assign c90   = gen90 & ~kill90;
    assign c180  = ~gen0;
    assign c270  = ~gen90;
    assign c90_2 = gen90 & ~kill2;

    logic       lk1, er1, lk2, er2;
    logic [7:0] cnt1;
    logic [3:0] cnt2;
    logic [1:0] st1, st2;

    clk_phase_checker_hyper #(.LOCK_CYCLES(8), .ERR_CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr),
        .clk0_i(c0), .clk90_i(c90), .clk180_i(c180), .clk270_i(c270),
        .locked_o(lk1), .err_o(er1), .err_cnt_o(cnt1), .state_o(st1)
    );

    clk_phase_checker_hyper #(.LOCK_CYCLES(8), .ERR_CNT_W(4)) dut_w4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .clr_i(1'b0),
        .clk0_i(gen0), .clk90_i(c90_2), .clk180_i(c180), .clk270_i(c270),
        .locked_o(lk2), .err_o(er2), .err_cnt_o(cnt2), .state_o(st2)
    );

    typedef struct {
        logic [1:0] st;
        logic       lk;
        logic       er;
        logic [7:0] cnt;
        bit         d2;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    int    vectors = 0;
    int    miscompares = 0;

    task automatic push(string tag, logic [1:0] st, logic lk, logic er, logic [7:0] cnt, bit d2);
        exp_t e;
        e.st = st; e.lk = lk; e.er = er; e.cnt = cnt; e.d2 = d2;
        sb.push_back(e);
        tags.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t        e;
        string       t;
        logic [11:0] obs, expv;
        e = sb.pop_front();
        t = tags.pop_front();
        obs  = e.d2 ? {st2, lk2, er2, 4'h0, cnt2} : {st1, lk1, er1, cnt1};
        expv = {e.st, e.lk, e.er, e.cnt};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed st=%b lk=%b err=%b cnt=%0d, expected st=%b lk=%b err=%b cnt=%0d",
                   t, obs[11:10], obs[9], obs[8], obs[7:0],
                   expv[11:10], expv[9], expv[8], expv[7:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue expectation, advance one clock, compare.
    task automatic sx(string tag, logic [1:0] st, logic lk, logic er, logic [7:0] cnt, bit d2);
        push(tag, st, lk, er, cnt, d2);
        step();
        pop_check();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; en2 = 1'b0;
        #12;
        push("reset", 2'b00, 1'b0, 1'b0, 8'd0, 1'b0); pop_check();
        push("reset_w4", 2'b00, 1'b0, 1'b0, 8'd0, 1'b1); pop_check();
        step(); step();
        rst_n = 1'b1;

        // Initial acquisition and lock.
        en = 1'b1;
        sx("enter_acq", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        repeat (6) step();
        sx("pre_lock", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        sx("lock", 2'b10, 1'b1, 1'b0, 8'd0, 1'b0);

        // clk90 stuck low for three cycles.
        kill90 = 1'b1;
        sx("fault1", 2'b11, 1'b0, 1'b1, 8'd1, 1'b0);
        sx("fault2", 2'b11, 1'b0, 1'b1, 8'd2, 1'b0);
        sx("fault3", 2'b11, 1'b0, 1'b1, 8'd3, 1'b0);
        kill90 = 1'b0;
        repeat (3) step();
        sx("fault_sticky", 2'b11, 1'b0, 1'b1, 8'd3, 1'b0);
        clr = 1'b1;
        sx("clr_fault", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        clr = 1'b0;
        repeat (6) step();
        sx("relock_pre", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        sx("relock", 2'b10, 1'b1, 1'b0, 8'd0, 1'b0);

        // clr wins over a simultaneous bad cycle.
        kill90 = 1'b1; clr = 1'b1;
        sx("clr_vs_bad", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        kill90 = 1'b0; clr = 1'b0;
        repeat (6) step();
        sx("relock2_pre", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        sx("relock2", 2'b10, 1'b1, 1'b0, 8'd0, 1'b0);

        // Build LOCKED with err_cnt=2 via disable/re-enable, which retains errors.
        kill90 = 1'b1;
        sx("f2_a", 2'b11, 1'b0, 1'b1, 8'd1, 1'b0);
        sx("f2_b", 2'b11, 1'b0, 1'b1, 8'd2, 1'b0);
        kill90 = 1'b0; en = 1'b0;
        sx("en_off_keeps_err", 2'b00, 1'b0, 1'b1, 8'd2, 1'b0);
        en = 1'b1;
        sx("reacq", 2'b01, 1'b0, 1'b1, 8'd2, 1'b0);
        repeat (6) step();
        sx("lock_err2_pre", 2'b01, 1'b0, 1'b1, 8'd2, 1'b0);
        sx("lock_err2", 2'b10, 1'b1, 1'b1, 8'd2, 1'b0);

        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        push("async_reset", 2'b00, 1'b0, 1'b0, 8'd0, 1'b0); pop_check();
        step();
        rst_n = 1'b1;
        sx("rst_acq", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        repeat (6) step();
        sx("rst_relock_pre", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        sx("rst_relock", 2'b10, 1'b1, 1'b0, 8'd0, 1'b0);

        // clk0 held static during acquisition: counter restarts, no error.
        en = 1'b0;
        sx("idle", 2'b00, 1'b0, 1'b0, 8'd0, 1'b0);
        en = 1'b1;
        sx("g_acq", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        repeat (3) step();
        sx("g_cyc5", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        hold_val = gen0; hold0 = 1'b1;
        sx("g_cyc6", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        sx("g_cyc7", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        hold0 = 1'b0;
        repeat (7) step();
        sx("g_lock_pre", 2'b01, 1'b0, 1'b0, 8'd0, 1'b0);
        sx("g_lock", 2'b10, 1'b1, 1'b0, 8'd0, 1'b0);

        // 4-bit counter saturation under a permanent fault.
        en2 = 1'b1;
        sx("w4_acq", 2'b01, 1'b0, 1'b0, 8'd0, 1'b1);
        repeat (7) step();
        sx("w4_lock", 2'b10, 1'b1, 1'b0, 8'd0, 1'b1);
        kill2 = 1'b1;
        repeat (13) step();
        sx("w4_cnt14", 2'b11, 1'b0, 1'b1, 8'd14, 1'b1);
        sx("w4_cnt15", 2'b11, 1'b0, 1'b1, 8'd15, 1'b1);
        repeat (24) step();
        sx("w4_saturated", 2'b11, 1'b0, 1'b1, 8'd15, 1'b1);
        kill2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_phase_checker_hyper.md
CLK_PHASE_CHECKER_HYPER -- requirements
Module: clk_phase_checker_hyper

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 8, consecutive good cycles required to declare lock (range 1..255).
REQ-002 SHALL have parameter ERR_CNT_W, default 8, width of the error counter.
REQ-003 clk_i  input  1  checker clock; same clock that drives the quadrature clock generator.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  checker enable; low forces IDLE.
REQ-006 clr_i  input  1  synchronous clear of sticky error state and counter; re-arms acquisition.
REQ-007 clk0_i, clk90_i, clk180_i, clk270_i  input  1 each  divided quadrature clocks, treated as data.
REQ-008 locked_o  output  1  phase relationship verified.
REQ-009 err_o  output  1  sticky fault flag.
REQ-010 err_cnt_o  output  ERR_CNT_W  count of bad cycles since last clear, saturating.
REQ-011 state_o  output  2  FSM state: 00 IDLE, 01 ACQUIRE, 10 LOCKED, 11 FAULT.

Function
REQ-012 SHALL sample vector P = {clk0,clk90,clk180,clk270} on every posedge clk_i.
REQ-013 SHALL capture vector N = {clk0,clk90,clk180,clk270} on every negedge clk_i; the posedge logic evaluates the most recent N.
REQ-014 P-check passes iff P0==P90, P180==P270, P0!=P180.
REQ-015 N-check passes iff N0==N270, N90==N180, N0!=N90.
REQ-016 Toggle-check passes iff P0 != P0 of the previous posedge; skipped on the first posedge after entering ACQUIRE.
REQ-017 A cycle is good iff the P-, N- and toggle-checks all pass; otherwise it is bad.
REQ-018 IDLE: en_i=1 -> ACQUIRE next cycle, good counter cleared.
REQ-019 ACQUIRE: good cycle increments the good counter; bad cycle resets it to 0 with no error recorded; counter reaching LOCK_CYCLES -> LOCKED.
REQ-020 LOCKED: locked_o=1; bad cycle -> FAULT, err_o set, err_cnt_o incremented.
REQ-021 FAULT: locked_o=0; each further bad cycle increments err_cnt_o; remains in FAULT until clr_i.
REQ-022 clr_i=1 in LOCKED or FAULT -> ACQUIRE, good counter cleared, err_o=0, err_cnt_o=0; clr_i in IDLE or ACQUIRE clears err_o, err_cnt_o and the good counter only.
REQ-023 clr_i has priority over a simultaneous bad cycle: no increment and no flag set in that cycle.
REQ-024 en_i=0 in any state -> IDLE next cycle, locked_o=0, good counter cleared; err_o and err_cnt_o retained.
REQ-025 err_cnt_o SHALL saturate at 2^ERR_CNT_W-1 and never wrap.
REQ-026 All outputs registered; locked_o rises one cycle after the LOCK_CYCLES-th consecutive good cycle.

Reset
REQ-027 With rst_ni low: state IDLE, locked_o=0, err_o=0, err_cnt_o=0, good counter 0, previous-P0 register 0, N register 0; takes effect without a clock edge.
REQ-028 Reset deasserted mid-operation SHALL restart from IDLE; no state is preserved.

Verification
REQ-029 Quadrature clocks driven by a reference divide-by-2 generator on the same clk_i, en_i=1 -> state_o=10, locked_o=1 after 8 good posedges plus 1; err_cnt_o=0.
REQ-030 Locked, then clk90_i forced to 0 for 3 cycles -> FAULT, err_o=1, err_cnt_o=3, locked_o=0; restore clocks, pulse clr_i -> ACQUIRE, relock after 9 cycles.
REQ-031 ACQUIRE with clk0_i held static at cycle 5 -> good counter resets, err_o stays 0, lock delayed to 8 good cycles after the glitch.
REQ-032 ERR_CNT_W=4, permanent fault for 40 cycles -> err_cnt_o saturates at 15.
REQ-033 clr_i asserted in the same cycle as a bad cycle in LOCKED -> err_o=0, err_cnt_o=0, state ACQUIRE.
REQ-034 rst_ni pulsed low while LOCKED with err_cnt_o=2 -> all outputs 0 immediately; en_i held high -> relock after 9 cycles.
